// File: rtl/seg7_pkg.sv
// Shared seven-segment constants: active-low patterns, bit 6 = a down to bit 0 = g.
package seg7_pkg;

  localparam logic [6:0] SEG_0     = 7'b0000001;
  localparam logic [6:0] SEG_1     = 7'b1001111;
  localparam logic [6:0] SEG_2     = 7'b0010010;
  localparam logic [6:0] SEG_3     = 7'b0000110;
  localparam logic [6:0] SEG_4     = 7'b1001100;
  localparam logic [6:0] SEG_5     = 7'b0100100;
  localparam logic [6:0] SEG_6     = 7'b0100000;
  localparam logic [6:0] SEG_7     = 7'b0001111;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0000100;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  localparam logic [3:0] BCD_MAX   = 4'd9;

endpackage

// File: rtl/seg7_decode.sv
// Combinational BCD digit to active-low seven-segment decoder.
// Codes above 9 cannot occur in a healthy counter and show as blank.
module seg7_decode
  import seg7_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    case (bcd)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/bcd_scan_counter.sv
// Multi-digit up/down BCD counter with a time-multiplexed seven-segment
// display scanner and optional leading-zero blanking.
module bcd_scan_counter
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS = 6,
  parameter int TICK_DIV   = 25000000,
  parameter int SCAN_DIV   = 50000,
  parameter int BLANK_LZ   = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic                    up_dn,
  input  logic                    clear,
  output logic [4*NUM_DIGITS-1:0] count,
  output logic                    wrap,
  output logic [6:0]              seg,
  output logic [NUM_DIGITS-1:0]   sel
);

  localparam int CW     = 4 * NUM_DIGITS;
  localparam int TICK_W = $clog2(TICK_DIV);
  localparam int SCAN_W = $clog2(SCAN_DIV);
  localparam int IDX_W  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  // ---------------- count prescaler ----------------
  logic [TICK_W-1:0] tick_cnt;
  logic              tick_last;
  logic              tick;

  assign tick_last = (tick_cnt == TICK_W'(TICK_DIV - 1));
  assign tick      = en & tick_last;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tick_cnt <= '0;
    end else if (clear) begin
      tick_cnt <= '0;
    end else if (en) begin
      tick_cnt <= tick_last ? '0 : tick_cnt + TICK_W'(1);
    end
  end

  // ---------------- BCD carry/borrow chain ----------------
  logic [CW-1:0] count_next;
  logic          carry;
  logic [3:0]    digit;

  // carry doubles as borrow when counting down; surviving past the top digit is a wrap
  always_comb begin
    count_next = count;
    carry      = 1'b1;
    digit      = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      digit = count[4*i +: 4];
      if (carry) begin
        if (up_dn) begin
          if (digit >= BCD_MAX) begin
            count_next[4*i +: 4] = 4'd0;
            carry                = 1'b1;
          end else begin
            count_next[4*i +: 4] = digit + 4'd1;
            carry                = 1'b0;
          end
        end else begin
          if (digit == 4'd0) begin
            count_next[4*i +: 4] = BCD_MAX;
            carry                = 1'b1;
          end else begin
            count_next[4*i +: 4] = digit - 4'd1;
            carry                = 1'b0;
          end
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
      wrap  <= 1'b0;
    end else if (clear) begin
      count <= '0;
      wrap  <= 1'b0;
    end else if (tick) begin
      count <= count_next;
      wrap  <= carry;
    end else begin
      wrap  <= 1'b0;
    end
  end

  // ---------------- scan prescaler and digit index ----------------
  logic [SCAN_W-1:0] scan_cnt;
  logic              scan_last;
  logic [IDX_W-1:0]  index;

  assign scan_last = (scan_cnt == SCAN_W'(SCAN_DIV - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scan_cnt <= '0;
      index    <= '0;
    end else begin
      scan_cnt <= scan_last ? '0 : scan_cnt + SCAN_W'(1);
      if (scan_last) begin
        index <= (index == IDX_W'(NUM_DIGITS - 1)) ? '0 : index + IDX_W'(1);
      end
    end
  end

  // ---------------- leading-zero detection ----------------
  logic                  zero_above;
  logic [NUM_DIGITS-1:0] blank_vec;

  always_comb begin
    zero_above = 1'b1;
    blank_vec  = '0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      zero_above   = zero_above & (count[4*i +: 4] == 4'd0);
      blank_vec[i] = (BLANK_LZ != 0) && (i > 0) && zero_above;
    end
  end

  // ---------------- digit selection and display registers ----------------
  logic [3:0]            cur_digit;
  logic                  cur_blank;
  logic [NUM_DIGITS-1:0] sel_next;
  logic [6:0]            dec_seg;
  logic [6:0]            seg_next;

  always_comb begin
    cur_digit = '0;
    cur_blank = 1'b0;
    sel_next  = '1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (index == IDX_W'(i)) begin
        cur_digit   = count[4*i +: 4];
        cur_blank   = blank_vec[i];
        sel_next[i] = 1'b0;
      end
    end
  end

  seg7_decode u_decode (
    .bcd (cur_digit),
    .seg (dec_seg)
  );

  assign seg_next = cur_blank ? SEG_BLANK : dec_seg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sel <= ~NUM_DIGITS'(1);
      seg <= SEG_0;
    end else begin
      sel <= sel_next;
      seg <= seg_next;
    end
  end

endmodule

// File: tb/tb_bcd_scan_counter.sv
// Directed bench for bcd_scan_counter with NUM_DIGITS=3, TICK_DIV=4, SCAN_DIV=2.
module tb_bcd_scan_counter;

  logic        clk;
  logic        rst;
  logic        en;
  logic        up_dn;
  logic        clear;
  logic [11:0] count;
  logic        wrap;
  logic [6:0]  seg;
  logic [2:0]  sel;

  int checks   = 0;
  int failures = 0;

  logic [6:0] seg_tbl [10];
  logic [2:0] slot_sel [3];
  logic [6:0] slot_seg [3];

  bcd_scan_counter #(
    .NUM_DIGITS (3),
    .TICK_DIV   (4),
    .SCAN_DIV   (2),
    .BLANK_LZ   (1)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .en    (en),
    .up_dn (up_dn),
    .clear (clear),
    .count (count),
    .wrap  (wrap),
    .seg   (seg),
    .sel   (sel)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- helpers ----------------
  function automatic logic [11:0] bcd3(input int n);
    return {4'(n / 100), 4'((n / 10) % 10), 4'(n % 10)};
  endfunction

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advances at least one cycle, then waits (bounded) for the wanted select.
  task automatic wait_sel(input logic [2:0] want, input string tag);
    int n;
    n = 0;
    step(1);
    while (sel !== want && n < 20) begin
      step(1);
      n++;
    end
    check(tag, 32'(sel), 32'(want));
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    seg_tbl[0] = 7'b0000001; seg_tbl[1] = 7'b1001111;
    seg_tbl[2] = 7'b0010010; seg_tbl[3] = 7'b0000110;
    seg_tbl[4] = 7'b1001100; seg_tbl[5] = 7'b0100100;
    seg_tbl[6] = 7'b0100000; seg_tbl[7] = 7'b0001111;
    seg_tbl[8] = 7'b0000000; seg_tbl[9] = 7'b0000100;
    slot_sel[0] = 3'b110; slot_seg[0] = 7'b0001111;
    slot_sel[1] = 3'b101; slot_seg[1] = 7'b1111111;
    slot_sel[2] = 3'b011; slot_seg[2] = 7'b1111111;

    rst   = 1'b1;
    en    = 1'b0;
    up_dn = 1'b1;
    clear = 1'b0;
    step(2);

    // reset state
    check("rst_count", 32'(count), 32'h000);
    check("rst_wrap",  32'(wrap),  32'h0);
    check("rst_sel",   32'(sel),   32'(3'b110));
    check("rst_seg",   32'(seg),   32'(7'b0000001));

    // release and count up: first step four cycles after release
    rst = 1'b0;
    en  = 1'b1;
    step(3);
    check("first_tick_wait", 32'(count), 32'h000);
    step(1);
    for (int k = 1; k <= 10; k++) begin
      if (k > 1) step(4);
      check("up_count", 32'(count), 32'(bcd3(k)));
      en = 1'b0;
      wait_sel(3'b110, "scan_to_d0");
      check("seg_d0", 32'(seg), 32'(seg_tbl[k % 10]));
      check("en0_hold", 32'(count), 32'(bcd3(k)));
      en = 1'b1;
    end

    // up to 999 then wrap to 000
    step(4 * 989);
    check("pre_999", 32'(count), 32'h999);
    check("pre_999_wrap", 32'(wrap), 32'h0);
    step(4);
    check("up_wrap_count", 32'(count), 32'h000);
    check("up_wrap_pulse", 32'(wrap), 32'h1);
    step(1);
    check("up_wrap_end", 32'(wrap), 32'h0);
    check("up_wrap_hold", 32'(count), 32'h000);

    // down from 000 wraps to 999, then 998
    up_dn = 1'b0;
    step(3);
    check("dn_wrap_count", 32'(count), 32'h999);
    check("dn_wrap_pulse", 32'(wrap), 32'h1);
    step(4);
    check("dn_998", 32'(count), 32'h998);
    check("dn_998_wrap", 32'(wrap), 32'h0);

    // clear, count to 057, then clear on the tick cycle
    clear = 1'b1;
    step(1);
    clear = 1'b0;
    up_dn = 1'b1;
    check("clear_count", 32'(count), 32'h000);
    check("clear_wrap", 32'(wrap), 32'h0);
    step(4 * 57);
    check("at_057", 32'(count), 32'h057);
    step(3);
    check("tick_cycle_057", 32'(count), 32'h057);
    clear = 1'b1;
    step(1);
    clear = 1'b0;
    check("clear_beats_tick", 32'(count), 32'h000);
    step(4);
    check("after_clear_step", 32'(count), 32'h001);

    // count 007: scan slots with leading-zero blanking
    step(4 * 6);
    check("at_007", 32'(count), 32'h007);
    en = 1'b0;
    wait_sel(3'b110, "scan_sync");
    for (int s = 0; s < 6; s++) begin
      if (s > 0) step(2);
      check("slot_sel", 32'(sel), 32'(slot_sel[s % 3]));
      check("slot_seg", 32'(seg), 32'(slot_seg[s % 3]));
    end

    // count 123, then reset mid-prescale
    clear = 1'b1;
    step(1);
    clear = 1'b0;
    en    = 1'b1;
    step(4 * 123);
    check("at_123", 32'(count), 32'h123);
    step(2);
    rst = 1'b1;
    #1;
    check("async_rst_count", 32'(count), 32'h000);
    check("async_rst_sel",   32'(sel),   32'(3'b110));
    check("async_rst_seg",   32'(seg),   32'(7'b0000001));
    check("async_rst_wrap",  32'(wrap),  32'h0);
    step(1);
    rst = 1'b0;
    step(3);
    check("post_rst_wait", 32'(count), 32'h000);
    step(1);
    check("post_rst_tick", 32'(count), 32'h001);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
